pipeline_mdu: RTL

PIPELINE_MDU -- requirements
Module: pipeline_mdu

---
 rtl/pipeline_mdu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_mdu.sv
// RV-M multiply/divide unit with a three-state IDLE/CALC/DONE sequencer.
// Divides (and multiplies when FAST_MUL=0) iterate one bit per cycle on
// operand magnitudes; the sign fix-up is applied on the way into DONE.
module pipeline_mdu #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   dv_q, dv_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [4:0]        rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, iter_in;
  logic [2*XLEN-1:0] ax, bx, prod_fast;
  logic [XLEN-1:0]   quick_res;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_res;

  // Decode the incoming request: signedness, magnitudes and the single-cycle result.
  always_comb begin
    a_signed  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg     = a_signed & a[XLEN-1];
    b_neg     = b_signed & b[XLEN-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    div_zero  = op[2] & (b == '0);
    ovf       = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
    iter_in   = op[2] ? ~(div_zero | ovf) : (FAST_MUL == 0);
    ax        = {{XLEN{a_neg}}, a};
    bx        = {{XLEN{b_neg}}, b};
    prod_fast = ax * bx;
    if (op[2]) begin
      if (div_zero) quick_res = op[1] ? a : '1;
      else          quick_res = op[1] ? '0 : a;
    end else begin
      quick_res = (op == 3'd0) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
    end
  end

  // One iteration: restoring-divide step or shift-add multiply step on {hi,lo}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, dv_q};
    if (op_q[2]) begin
      if (!div_trial[XLEN]) begin
        step_hi = div_trial[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign-correct the final iteration's output into the architectural result.
  always_comb begin
    prod = {step_hi, step_lo};
    if (negq_q) prod = ~prod + 1'b1;
    quo = negq_q ? (~step_lo + 1'b1) : step_lo;
    rem = negr_q ? (~step_hi + 1'b1) : step_hi;
    if (op_q[2]) fin_res = op_q[1] ? rem : quo;
    else         fin_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush returns to IDLE without touching result/rd_out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dv_d      = dv_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d  = S_DONE;
            result_d = fin_res;
            rd_out_d = rd_pend_q;
          end
        end
        default: begin
          if (start) begin
            op_d      = op;
            rd_pend_d = rd_in;
            negq_d    = a_neg ^ b_neg;
            negr_d    = a_neg;
            if (iter_in) begin
              state_d = S_CALC;
              cnt_d   = '0;
              hi_d    = '0;
              lo_d    = op[2] ? a_mag : b_mag;
              dv_d    = op[2] ? b_mag : a_mag;
            end else begin
              state_d  = S_DONE;
              result_d = quick_res;
              rd_out_d = rd_in;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dv_q      <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dv_q      <= dv_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign stall  = busy | (start & ~busy & iter_in);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
